// File: rtl/data_cache_axi_bridge_if.sv
// Cache-request and single-beat AXI signal bundle for the data-cache bridge.
// master = the bridge (AXI master, cache responder); slave = cache plus interconnect.
interface data_cache_axi_bridge_if;
    logic        data_cache_req;
    logic [3:0]  data_cache_wen;
    logic [31:0] data_cache_addr;
    logic [31:0] data_cache_wdata;
    logic [31:0] data_cache_rdata;
    logic        data_cache_dok;

    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  data_cache_req, data_cache_wen, data_cache_addr, data_cache_wdata,
        output data_cache_rdata, data_cache_dok,
        output arid, arlen, arsize, arburst, araddr, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid,
        output awid, awlen, awsize, awburst, awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        output data_cache_req, data_cache_wen, data_cache_addr, data_cache_wdata,
        input  data_cache_rdata, data_cache_dok,
        input  arid, arlen, arsize, arburst, araddr, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid,
        input  awid, awlen, awsize, awburst, awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/data_cache_axi_bridge.sv
// Turns each data-cache request into one single-beat AXI read or write.
// One transaction in flight; dok pulses for one cycle on completion.
module data_cache_axi_bridge #(
    parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF
) (
    input logic                    clk,
    input logic                    resetn,
    data_cache_axi_bridge_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_t;

    state_t state;
    logic   aw_done, w_done;
    logic   aw_hs, w_hs;
    logic   unused_resp;

    assign aw_hs = bus.awvalid & bus.awready;
    assign w_hs  = bus.wvalid & bus.wready;

    // Single-beat, 4-byte INCR, ID 0; responses complete the request whatever their code.
    assign bus.arid    = 4'd0;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = 3'd2;
    assign bus.arburst = 2'b01;
    assign bus.awid    = 4'd0;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = 3'd2;
    assign bus.awburst = 2'b01;
    assign bus.wlast   = bus.wvalid;
    assign unused_resp = ^{bus.rresp, bus.rlast, bus.bresp};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state                <= IDLE;
            aw_done              <= 1'b0;
            w_done               <= 1'b0;
            bus.arvalid          <= 1'b0;
            bus.rready           <= 1'b0;
            bus.awvalid          <= 1'b0;
            bus.wvalid           <= 1'b0;
            bus.bready           <= 1'b0;
            bus.data_cache_dok   <= 1'b0;
            bus.data_cache_rdata <= 32'd0;
            bus.araddr           <= 32'd0;
            bus.awaddr           <= 32'd0;
            bus.wdata            <= 32'd0;
            bus.wstrb            <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.data_cache_req) begin
                        if (bus.data_cache_wen == 4'd0) begin
                            bus.araddr  <= bus.data_cache_addr & PHYS_MASK;
                            bus.arvalid <= 1'b1;
                            state       <= RD_ADDR;
                        end else begin
                            bus.awaddr  <= bus.data_cache_addr & PHYS_MASK;
                            bus.wdata   <= bus.data_cache_wdata;
                            bus.wstrb   <= bus.data_cache_wen;
                            bus.awvalid <= 1'b1;
                            bus.wvalid  <= 1'b1;
                            state       <= WR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (bus.arready) begin
                        bus.arvalid <= 1'b0;
                        bus.rready  <= 1'b1;
                        state       <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.rvalid) begin
                        bus.data_cache_rdata <= bus.rdata;
                        bus.rready           <= 1'b0;
                        bus.data_cache_dok   <= 1'b1;
                        state                <= DONE;
                    end
                end
                WR: begin
                    // AW and W complete independently; each valid drops after its own handshake.
                    if (aw_hs) bus.awvalid <= 1'b0;
                    if (w_hs)  bus.wvalid  <= 1'b0;
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        bus.bready <= 1'b1;
                        state      <= WR_RESP;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bus.bvalid) begin
                        bus.bready         <= 1'b0;
                        bus.data_cache_dok <= 1'b1;
                        state              <= DONE;
                    end
                end
                DONE: begin
                    bus.data_cache_dok <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_cache_axi_bridge.sv
// Bench for data_cache_axi_bridge: delay-configurable AXI slave, bus logs, expected-transaction queue.
module tb_data_cache_axi_bridge;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    data_cache_axi_bridge_if bus();

    data_cache_axi_bridge #(.PHYS_MASK(32'h1FFF_FFFF)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;

    typedef struct {
        int dok;
        int b;
        int arv;
        int awv_only;
        int wv_only;
        int first_aw;
    } obs_t;

    txn_t        exp_q[$];
    logic [31:0] ar_log[$];
    logic [31:0] aw_log[$];
    logic [36:0] w_log[$];

    int n_vec = 0;
    int n_err = 0;

    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] rdata_val = 32'd0;
    logic [1:0]  bresp_val = 2'b00;
    logic [31:0] last_rd = 32'd0;

    // AXI slave: ready/valid rises after the configured number of cycles of seeing the request.
    initial begin
        int ar_seen, r_seen, aw_seen, w_seen, b_seen;
        ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 1;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        forever begin
            @(posedge clk); #1;
            if (!resetn) begin
                bus.arready = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
                ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0;
            end else begin
                if (bus.arvalid) begin bus.arready = (ar_seen >= ar_dly); ar_seen++; end
                else begin bus.arready = 0; ar_seen = 0; end
                if (bus.rready) begin bus.rvalid = (r_seen >= r_dly); r_seen++; end
                else begin bus.rvalid = 0; r_seen = 0; end
                bus.rdata = bus.rvalid ? rdata_val : 32'hBAD0_0000;
                if (bus.awvalid) begin bus.awready = (aw_seen >= aw_dly); aw_seen++; end
                else begin bus.awready = 0; aw_seen = 0; end
                if (bus.wvalid) begin bus.wready = (w_seen >= w_dly); w_seen++; end
                else begin bus.wready = 0; w_seen = 0; end
                if (bus.bready) begin bus.bvalid = (b_seen >= b_dly); b_seen++; end
                else begin bus.bvalid = 0; b_seen = 0; end
                bus.bresp = bresp_val;
            end
        end
    end

    always @(posedge clk) begin
        if (resetn) begin
            if (bus.arvalid && bus.arready) ar_log.push_back(bus.araddr);
            if (bus.awvalid && bus.awready) aw_log.push_back(bus.awaddr);
            if (bus.wvalid && bus.wready)   w_log.push_back({bus.wlast, bus.wstrb, bus.wdata});
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic clear_logs();
        ar_log.delete(); aw_log.delete(); w_log.delete();
    endtask

    task automatic issue(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd_exp);
        txn_t t;
        bus.data_cache_req   = 1'b1;
        bus.data_cache_wen   = wen;
        bus.data_cache_addr  = addr;
        bus.data_cache_wdata = wd;
        t.addr = addr & 32'h1FFF_FFFF;
        t.data = (wen == 4'd0) ? rd_exp : wd;
        t.strb = wen;
        exp_q.push_back(t);
    endtask

    // Cycle numbers are relative to the cycle in which the request was presented (cycle 0).
    task automatic wait_dok(output obs_t o);
        o.dok = -1; o.b = -1; o.arv = 0; o.awv_only = 0; o.wv_only = 0; o.first_aw = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.arvalid) o.arv++;
            if (bus.awvalid && !bus.wvalid) o.awv_only++;
            if (bus.wvalid && !bus.awvalid) o.wv_only++;
            if (bus.awvalid && o.first_aw < 0) o.first_aw = c;
            if (bus.bvalid && bus.bready) o.b = c;
            if (bus.data_cache_dok) begin o.dok = c; break; end
        end
    endtask

    task automatic test_reset();
        bus.data_cache_req = 0; bus.data_cache_wen = 0; bus.data_cache_addr = 0; bus.data_cache_wdata = 0;
        resetn = 1'b0;
        repeat (3) tick();
        n_vec++; if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.data_cache_dok} !== 7'd0) begin
            n_err++; $display("FAIL reset_valids: got %b want 0000000",
                {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.data_cache_dok}); end
        n_vec++; if ({bus.data_cache_rdata, bus.araddr, bus.awaddr, bus.wdata, bus.wstrb} !== 132'd0) begin
            n_err++; $display("FAIL reset_data: got rdata=%h araddr=%h awaddr=%h wdata=%h wstrb=%h want all 0",
                bus.data_cache_rdata, bus.araddr, bus.awaddr, bus.wdata, bus.wstrb); end
        n_vec++; if ({bus.arid, bus.arlen, bus.arsize, bus.arburst, bus.awid, bus.awlen, bus.awsize, bus.awburst}
                     !== {4'd0, 8'd0, 3'd2, 2'b01, 4'd0, 8'd0, 3'd2, 2'b01}) begin
            n_err++; $display("FAIL tieoffs: got ar=%h/%h/%h/%h aw=%h/%h/%h/%h want 0/0/2/1",
                bus.arid, bus.arlen, bus.arsize, bus.arburst, bus.awid, bus.awlen, bus.awsize, bus.awburst); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_read_zero_wait();
        obs_t o; txn_t e;
        ar_dly = 0; r_dly = 0; rdata_val = 32'hDEAD_BEEF;
        clear_logs();
        issue(4'd0, 32'hBFC0_0010, 32'h0, 32'hDEAD_BEEF);
        wait_dok(o);
        e = exp_q.pop_front();
        n_vec++; if (o.dok !== 3) begin n_err++; $display("FAIL rd0_dok_cycle: got %0d want 3", o.dok); end
        n_vec++; if (bus.data_cache_rdata !== e.data) begin n_err++; $display("FAIL rd0_rdata: got %h want %h", bus.data_cache_rdata, e.data); end
        n_vec++; if (ar_log.size() !== 1 || ar_log[0] !== e.addr) begin
            n_err++; $display("FAIL rd0_araddr: got n=%0d addr=%h want n=1 addr=%h", ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 32'hx, e.addr); end
        last_rd = e.data;
        bus.data_cache_req = 1'b0;
        tick();
        n_vec++; if ({bus.data_cache_dok, bus.arvalid} !== 2'b00) begin n_err++; $display("FAIL rd0_dok_width: got dok,arvalid=%b want 00", {bus.data_cache_dok, bus.arvalid}); end
        n_vec++; if (aw_log.size() !== 0 || w_log.size() !== 0) begin n_err++; $display("FAIL rd0_no_write: got aw=%0d w=%0d want 0 0", aw_log.size(), w_log.size()); end
    endtask

    task automatic test_read_delayed();
        obs_t o; txn_t e;
        ar_dly = 3; r_dly = 2; rdata_val = 32'h0BAD_F00D;
        clear_logs();
        issue(4'd0, 32'h8000_1000, 32'hFFFF_FFFF, 32'h0BAD_F00D);
        wait_dok(o);
        e = exp_q.pop_front();
        n_vec++; if (o.dok !== 8) begin n_err++; $display("FAIL rdd_dok_cycle: got %0d want 8", o.dok); end
        n_vec++; if (o.arv !== 4) begin n_err++; $display("FAIL rdd_arvalid_hold: got %0d cycles want 4", o.arv); end
        n_vec++; if (ar_log.size() !== 1 || ar_log[0] !== e.addr) begin
            n_err++; $display("FAIL rdd_single_ar: got n=%0d addr=%h want n=1 addr=%h", ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 32'hx, e.addr); end
        n_vec++; if (bus.data_cache_rdata !== e.data) begin n_err++; $display("FAIL rdd_rdata: got %h want %h", bus.data_cache_rdata, e.data); end
        last_rd = e.data;
        bus.data_cache_req = 1'b0;
        tick();
        ar_dly = 0; r_dly = 0;
    endtask

    task automatic test_write_aw_first();
        obs_t o; txn_t e;
        aw_dly = 0; w_dly = 2; b_dly = 0; bresp_val = 2'b00;
        clear_logs();
        issue(4'b0011, 32'h8000_0004, 32'h1234_5678, 32'h0);
        wait_dok(o);
        e = exp_q.pop_front();
        n_vec++; if (o.dok !== 5 || o.dok !== o.b + 1) begin n_err++; $display("FAIL wra_dok_cycle: got dok=%0d b=%0d want dok=5 b=4", o.dok, o.b); end
        n_vec++; if (o.wv_only !== 2 || o.awv_only !== 0) begin
            n_err++; $display("FAIL wra_valid_split: got w_only=%0d aw_only=%0d want 2 0", o.wv_only, o.awv_only); end
        n_vec++; if (aw_log.size() !== 1 || aw_log[0] !== e.addr) begin
            n_err++; $display("FAIL wra_awaddr: got n=%0d addr=%h want n=1 addr=%h", aw_log.size(), (aw_log.size() > 0) ? aw_log[0] : 32'hx, e.addr); end
        n_vec++; if (w_log.size() !== 1 || w_log[0] !== {1'b1, e.strb, e.data}) begin
            n_err++; $display("FAIL wra_wbeat: got n=%0d beat=%h want n=1 beat=%h", w_log.size(), (w_log.size() > 0) ? w_log[0] : 37'hx, {1'b1, e.strb, e.data}); end
        n_vec++; if (bus.data_cache_rdata !== last_rd) begin n_err++; $display("FAIL wra_rdata_hold: got %h want %h", bus.data_cache_rdata, last_rd); end
        bus.data_cache_req = 1'b0;
        tick();
    endtask

    task automatic test_write_w_first();
        obs_t o; txn_t e;
        aw_dly = 2; w_dly = 0; b_dly = 1; bresp_val = 2'b10;
        clear_logs();
        issue(4'b1100, 32'hA000_0100, 32'hCAFE_F00D, 32'h0);
        wait_dok(o);
        e = exp_q.pop_front();
        n_vec++; if (o.dok !== 6 || o.b !== 5) begin n_err++; $display("FAIL wrw_dok_cycle: got dok=%0d b=%0d want dok=6 b=5", o.dok, o.b); end
        n_vec++; if (o.awv_only !== 2 || o.wv_only !== 0) begin
            n_err++; $display("FAIL wrw_valid_split: got aw_only=%0d w_only=%0d want 2 0", o.awv_only, o.wv_only); end
        n_vec++; if (aw_log.size() !== 1 || w_log.size() !== 1) begin n_err++; $display("FAIL wrw_once: got aw=%0d w=%0d want 1 1", aw_log.size(), w_log.size()); end
        n_vec++; if (w_log.size() > 0 && w_log[0] !== {1'b1, e.strb, e.data}) begin
            n_err++; $display("FAIL wrw_wbeat: got %h want %h", w_log[0], {1'b1, e.strb, e.data}); end
        bus.data_cache_req = 1'b0;
        repeat (3) tick();
        n_vec++; if (aw_log.size() !== 1 || bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0) begin
            n_err++; $display("FAIL wrw_no_retry: got aw=%0d awvalid=%b wvalid=%b want 1 0 0", aw_log.size(), bus.awvalid, bus.wvalid); end
        aw_dly = 0; w_dly = 0; b_dly = 0; bresp_val = 2'b00;
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2; txn_t e1, e2;
        rdata_val = 32'h5555_AAAA;
        clear_logs();
        issue(4'd0, 32'h0000_2000, 32'h0, 32'h5555_AAAA);
        wait_dok(o1);
        e1 = exp_q.pop_front();
        issue(4'b1111, 32'hBFC0_0020, 32'h7777_8888, 32'h0);
        wait_dok(o2);
        e2 = exp_q.pop_front();
        bus.data_cache_req = 1'b0;
        n_vec++; if (o1.dok !== 3 || o2.dok !== 4) begin n_err++; $display("FAIL b2b_dok_cycles: got %0d,%0d want 3,4", o1.dok, o2.dok); end
        n_vec++; if (o2.first_aw !== 2) begin n_err++; $display("FAIL b2b_latch_cycle: got awvalid first at +%0d want +2", o2.first_aw); end
        n_vec++; if (ar_log.size() !== 1 || aw_log.size() !== 1 || w_log.size() !== 1) begin
            n_err++; $display("FAIL b2b_counts: got ar=%0d aw=%0d w=%0d want 1 1 1", ar_log.size(), aw_log.size(), w_log.size()); end
        n_vec++; if (ar_log.size() > 0 && aw_log.size() > 0 && (ar_log[0] !== e1.addr || aw_log[0] !== e2.addr)) begin
            n_err++; $display("FAIL b2b_addrs: got ar=%h aw=%h want %h %h", ar_log[0], aw_log[0], e1.addr, e2.addr); end
        n_vec++; if (bus.data_cache_rdata !== e1.data) begin n_err++; $display("FAIL b2b_rdata: got %h want %h", bus.data_cache_rdata, e1.data); end
        last_rd = e1.data;
        tick();
    endtask

    task automatic test_reset_mid();
        obs_t o; txn_t e;
        ar_dly = 0; r_dly = 20; rdata_val = 32'h2468_ACE0;
        clear_logs();
        issue(4'd0, 32'h9000_0040, 32'h0, 32'h2468_ACE0);
        void'(exp_q.pop_front());
        tick(); tick();
        n_vec++; if (bus.rready !== 1'b1) begin n_err++; $display("FAIL rst_pre_rready: got %b want 1", bus.rready); end
        #1 resetn = 1'b0;
        bus.data_cache_req = 1'b0;
        #1;
        n_vec++; if ({bus.arvalid, bus.rready, bus.data_cache_dok} !== 3'b000) begin
            n_err++; $display("FAIL rst_async: got arvalid,rready,dok=%b want 000", {bus.arvalid, bus.rready, bus.data_cache_dok}); end
        tick();
        resetn = 1'b1;
        tick();
        n_vec++; if ({bus.arvalid, bus.rready, bus.data_cache_rdata} !== 34'd0) begin
            n_err++; $display("FAIL rst_idle: got arvalid=%b rready=%b rdata=%h want 0 0 0", bus.arvalid, bus.rready, bus.data_cache_rdata); end
        r_dly = 0; rdata_val = 32'h1357_9BDF;
        clear_logs();
        issue(4'd0, 32'h8000_0080, 32'h0, 32'h1357_9BDF);
        wait_dok(o);
        e = exp_q.pop_front();
        bus.data_cache_req = 1'b0;
        n_vec++; if (o.dok !== 3) begin n_err++; $display("FAIL rst_fresh_dok: got %0d want 3", o.dok); end
        n_vec++; if (ar_log.size() !== 1 || ar_log[0] !== e.addr || bus.data_cache_rdata !== e.data) begin
            n_err++; $display("FAIL rst_fresh_read: got n=%0d addr=%h rdata=%h want n=1 addr=%h rdata=%h",
                ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 32'hx, bus.data_cache_rdata, e.addr, e.data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_read_delayed();
        test_write_aw_first();
        test_write_w_first();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_cache_axi_bridge.md
Name:
data_cache_axi_bridge

Overview:
- Responder end of the data-cache request interface (req/wen/addr/wdata in, rdata/dok out).
- Converts each cache request into exactly one single-beat AXI read (AR/R) or write (AW/W/B) transaction.
- Sits between the data cache and the AXI interconnect.
- One transaction outstanding at a time.
- AXI ID, len and burst are tied off at top level: ID 0, len 0, INCR, size 2 (4 bytes).

Parameters:
PHYS_MASK, 32'h1FFF_FFFF, AND-mask applied to the latched address before driving araddr/awaddr (kseg0/kseg1 to physical).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
data_cache_req  in  1  request valid; held stable by cache until dok
data_cache_wen  in  4  byte write enables; 0 = read
data_cache_addr  in  32  virtual byte address
data_cache_wdata  in  32  write data
data_cache_rdata  out  32  read data, valid while dok=1
data_cache_dok  out  1  one-cycle completion pulse
araddr  out  32  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rresp  in  2  read response (ignored except by test monitors)
rlast  in  1  last beat (always 1, single beat)
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  32  write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  write strobes
wlast  out  1  last write beat, equals wvalid
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response (ignored)
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Everything is sampled on the posedge of clk. resetn=0 asynchronously forces:
  - state IDLE;
  - all valid/ready outputs and dok to 0;
  - data_cache_rdata, araddr, awaddr, wdata and wstrb to 0;
  - aw_done and w_done to 0.
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE:
  - If req=1, latch addr&PHYS_MASK, wen and wdata.
  - Next state is RD_ADDR if wen==0, else WR.
  - If req=0, stay in IDLE.
- RD_ADDR:
  - arvalid=1 and araddr holds the latched address.
  - On arvalid&arready go to RD_DATA; arvalid deasserts the next cycle.
- RD_DATA:
  - rready=1.
  - On rvalid, capture rdata into data_cache_rdata and go to DONE.
- WR:
  - awvalid and wvalid are asserted together; wstrb=latched wen, wlast=wvalid.
  - Each channel is tracked independently with flags aw_done and w_done. A channel's valid drops the cycle after its own handshake; the other channel stays valid.
  - When both handshakes are complete (same cycle or different cycles), clear both flags and go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid go to DONE.
- DONE:
  - dok=1 for exactly this one cycle; rdata holds the captured value (unchanged by writes).
  - req is ignored in this cycle (the cache is still presenting the completed request).
  - Next state is IDLE.
- Minimum latency, counted from req accepted in IDLE (cycle 0), with dok in cycle 3:
  - read with arready and rvalid already high;
  - write with awready, wready and bvalid already high.
- Back-to-back requests: a new req is accepted in IDLE in the cycle after DONE. Throughput is at most one transaction per 4 cycles.
- Non-OKAY rresp/bresp are treated as completion; no retry.
- Changes on data_cache_* after latching have no effect until the next IDLE.
- Reset mid-transaction abandons the AXI transaction with no drain; the interconnect must be reset simultaneously.
- arvalid/awvalid/wvalid never drop before their handshake.

Test Plan:
- Read, zero-wait slave: req=1, wen=0, addr=0xBFC0_0010, rdata=0xDEAD_BEEF -> araddr=0x1FC0_0010 in cycle 1; dok=1 with data_cache_rdata=0xDEAD_BEEF in cycle 3, for 1 cycle only.
- Read with arready delayed 3 cycles and rvalid delayed 2 cycles after that -> arvalid held stable until handshake; dok in cycle 8; no second AR issued.
- Write, awready before wready: wen=4'b0011, addr=0x8000_0004, wdata=0x1234_5678 -> awaddr=0x0000_0004, awvalid drops after its handshake while wvalid persists; wstrb=4'b0011, wlast=1; dok exactly 1 cycle after the bvalid cycle.
- Write, wready before awready, with bresp=2'b10 -> both handshakes complete exactly once; dok asserted; no retry.
- Back-to-back read then write with req held continuously -> second request latched in the cycle after dok; exactly one AR and one AW/W on the bus.
- resetn pulsed low while in RD_DATA -> arvalid, rready and dok are 0 immediately (asynchronously); state IDLE; next req starts a fresh read.
